serial_flash_cmd: RTL and testbench
===================================

SERIAL_FLASH_CMD -- requirements
Module: serial_flash_cmd

Interface
REQ-001 SHALL have parameter WORD_BITS, default 8, data word width (one hex pair per word).
REQ-002 SHALL have parameter ADDRESS_WORDS, default 3, number of address words (address = 2*ADDRESS_WORDS hex digits).
REQ-003 SHALL have parameter MAIN_CLK, default 27_000_000, clk27 frequency in Hz.
REQ-004 SHALL have parameter TIMEOUT_MS, default 2000, inter-character timeout.
REQ-005 SHALL have port clk27  input  1  main clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_rx_char  input  WORD_BITS  received serial character.
REQ-008 SHALL have port in_rx_valid  input  1  one-cycle strobe, in_rx_char valid.
REQ-009 SHALL have port out_cmd_valid  output  1  flash request pending.
REQ-010 SHALL have port in_cmd_ack  input  1  flash stage accepted request.
REQ-011 SHALL have port out_cmd_read  output  1  1 = read, 0 = write.
REQ-012 SHALL have port out_cmd_addr  output  WORD_BITS*ADDRESS_WORDS  flash address.
REQ-013 SHALL have port out_cmd_data  output  WORD_BITS  write data (0 for reads).
REQ-014 SHALL have port out_err  output  1  one-cycle pulse on syntax error, timeout or overrun.
REQ-015 SHALL have port out_busy  output  1  high in every state except Idle.

Function
REQ-016 SHALL accept the line grammar: cmd SP addr [SP data] term; cmd 'R'/'r' (read) or 'W'/'w' (write); addr exactly 2*ADDRESS_WORDS hex digits, MSB first; data exactly 2 hex digits, write only; term CR (0x0D) or LF (0x0A).
REQ-017 SHALL accept hex digits 0-9, a-f, A-F; any other char where a digit is expected is a syntax error.
REQ-018 SHALL implement states Idle, Sep1, Addr, Sep2, Data, Term, Issue, Discard; input is consumed only on cycles with in_rx_valid=1.
REQ-019 Idle: 'R'/'r'/'W'/'w' -> Sep1 (latch read flag); CR/LF/SP -> stay Idle, no error; any other char -> Discard.
REQ-020 Sep1: SP -> Addr with digit counter 0 and address register cleared; otherwise -> Discard.
REQ-021 Addr: each hex digit: addr <= {addr[W-5:0], nibble}, counter +1; after last digit -> Term for read, Sep2 for write.
REQ-022 Sep2: SP -> Data; otherwise -> Discard. Data: two hex digits shifted in as for Addr, then -> Term.
REQ-023 Term: CR or LF -> Issue; otherwise -> Discard.
REQ-024 Issue: out_cmd_valid=1 from the cycle after the accepted terminator until the first cycle in_cmd_ack=1 is sampled; next cycle -> Idle, out_cmd_valid=0.
REQ-025 out_cmd_read, out_cmd_addr, out_cmd_data SHALL be stable while out_cmd_valid=1.
REQ-026 Discard: drop chars until CR or LF, then pulse out_err for exactly one cycle and -> Idle.
REQ-027 A char received in Issue SHALL be dropped and out_err pulsed one cycle; the pending request is unaffected.
REQ-028 In Sep1..Term or Discard, if no in_rx_valid occurs for MAIN_CLK/1000*TIMEOUT_MS cycles, SHALL pulse out_err and -> Idle; counter resets on every in_rx_valid and is idle in Idle/Issue.
REQ-029 If in_cmd_ack and in_rx_valid coincide in Issue: request completes and char is dropped with out_err pulse.
REQ-030 A terminator in Idle (e.g. LF after CR) SHALL be ignored silently.
REQ-031 out_cmd_data SHALL be forced to 0 for read commands.

Reset
REQ-032 On rst=1, immediately: state Idle, out_cmd_valid=0, out_cmd_read=1, out_cmd_addr=0, out_cmd_data=0, out_err=0, out_busy=0, counters 0.
REQ-033 Reset mid-line or during Issue SHALL abandon the request; partial input is discarded, no out_err.

Verification
REQ-034 "R 00012a\r", ack tied high -> one out_cmd_valid cycle, read=1, addr=0x00012A, data=0x00, no out_err.
REQ-035 "w ABCDEF 5f\n", ack delayed 10 cycles -> valid held 10+1 cycles, read=0, addr=0xABCDEF, data=0x5F, outputs stable.
REQ-036 "R 0012g4\r" -> no request, out_err single pulse on the CR cycle+1, back to Idle; following "R 000000\r" accepted.
REQ-037 "R 12" then silence > timeout -> out_err pulse, out_busy=0; "\r\n" alone -> no request, no error.
REQ-038 Char sent during Issue with ack held low -> out_err pulse, request still addr/data unchanged until ack.
REQ-039 rst asserted after "W 000010 " -> outputs at reset values, no request on later ack.

Source files
------------

// File: rtl/serial_flash_cmd.sv
// Line-oriented serial command parser: "R aaaaaa" / "W aaaaaa dd" + CR/LF becomes a
// flash read/write request held until acknowledged.
module serial_flash_cmd #(
  parameter int unsigned WORD_BITS     = 8,
  parameter int unsigned ADDRESS_WORDS = 3,
  parameter int unsigned MAIN_CLK      = 27_000_000,
  parameter int unsigned TIMEOUT_MS    = 2000
) (
  input  logic                               clk27,
  input  logic                               rst,
  input  logic [WORD_BITS-1:0]               in_rx_char,
  input  logic                               in_rx_valid,
  output logic                               out_cmd_valid,
  input  logic                               in_cmd_ack,
  output logic                               out_cmd_read,
  output logic [WORD_BITS*ADDRESS_WORDS-1:0] out_cmd_addr,
  output logic [WORD_BITS-1:0]               out_cmd_data,
  output logic                               out_err,
  output logic                               out_busy
);

  localparam int unsigned AddrBits      = WORD_BITS * ADDRESS_WORDS;
  localparam int unsigned AddrDigits    = 2 * ADDRESS_WORDS;
  localparam int unsigned DataDigits    = 2;
  localparam int unsigned TimeoutCycles = MAIN_CLK / 1000 * TIMEOUT_MS;
  localparam int unsigned CntBits       = $clog2(AddrDigits + 1);
  localparam int unsigned TmrBits       = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    StIdle, StSep1, StAddr, StSep2, StData, StTerm, StIssue, StDiscard
  } state_e;

  state_e             state_q;
  logic [CntBits-1:0] cnt_q;
  logic [TmrBits-1:0] timer_q;

  logic [7:0] ch;
  logic [3:0] nibble;
  logic       is_hex, is_term, is_sp, is_rd, is_wr;
  logic       char_ok, timeout;

  always_comb begin
    ch      = 8'(in_rx_char);
    is_term = (ch == 8'h0D) || (ch == 8'h0A);
    is_sp   = (ch == 8'h20);
    is_rd   = (ch == 8'h52) || (ch == 8'h72);
    is_wr   = (ch == 8'h57) || (ch == 8'h77);
    is_hex  = 1'b1;
    nibble  = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nibble = 4'(ch - 8'h30);
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      nibble = 4'(ch - 8'h37);
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      nibble = 4'(ch - 8'h57);
    end else begin
      is_hex = 1'b0;
    end

    // Character the grammar expects in the current mid-line state.
    case (state_q)
      StSep1, StSep2: char_ok = is_sp;
      StAddr, StData: char_ok = is_hex;
      StTerm:         char_ok = is_term;
      default:        char_ok = 1'b1;
    endcase

    timeout = (state_q != StIdle) && (state_q != StIssue) && !in_rx_valid &&
              (timer_q == TmrBits'(TimeoutCycles - 1));
  end

  always_ff @(posedge clk27 or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      timer_q       <= '0;
      out_cmd_valid <= 1'b0;
      out_cmd_read  <= 1'b1;
      out_cmd_addr  <= '0;
      out_cmd_data  <= '0;
      out_err       <= 1'b0;
      out_busy      <= 1'b0;
    end else begin
      out_err <= 1'b0;
      if (state_q == StIdle || state_q == StIssue || in_rx_valid) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TmrBits'(1);
      end

      if (timeout) begin
        state_q  <= StIdle;
        out_busy <= 1'b0;
        out_err  <= 1'b1;
      end else if (state_q == StIssue) begin
        // Overrun: the character is lost, the pending request is kept.
        if (in_rx_valid) out_err <= 1'b1;
        if (in_cmd_ack) begin
          state_q       <= StIdle;
          out_busy      <= 1'b0;
          out_cmd_valid <= 1'b0;
        end
      end else if (in_rx_valid) begin
        if (!char_ok) begin
          // A terminator ends the broken line now; anything else waits for one.
          if (is_term) begin
            state_q  <= StIdle;
            out_busy <= 1'b0;
            out_err  <= 1'b1;
          end else begin
            state_q <= StDiscard;
          end
        end else begin
          case (state_q)
            StIdle: begin
              if (is_rd || is_wr) begin
                state_q      <= StSep1;
                out_busy     <= 1'b1;
                out_cmd_read <= is_rd;
                out_cmd_data <= '0;
              end else if (!is_term && !is_sp) begin
                state_q  <= StDiscard;
                out_busy <= 1'b1;
              end
            end
            StSep1: begin
              state_q      <= StAddr;
              cnt_q        <= '0;
              out_cmd_addr <= '0;
            end
            StAddr: begin
              out_cmd_addr <= {out_cmd_addr[AddrBits-5:0], nibble};
              cnt_q        <= cnt_q + CntBits'(1);
              if (cnt_q == CntBits'(AddrDigits - 1)) begin
                state_q <= out_cmd_read ? StTerm : StSep2;
              end
            end
            StSep2: begin
              state_q <= StData;
              cnt_q   <= '0;
            end
            StData: begin
              out_cmd_data <= {out_cmd_data[WORD_BITS-5:0], nibble};
              cnt_q        <= cnt_q + CntBits'(1);
              if (cnt_q == CntBits'(DataDigits - 1)) state_q <= StTerm;
            end
            StTerm: begin
              state_q       <= StIssue;
              out_cmd_valid <= 1'b1;
            end
            StDiscard: begin
              if (is_term) begin
                state_q  <= StIdle;
                out_busy <= 1'b0;
                out_err  <= 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_flash_cmd.sv
// Bench for serial_flash_cmd: directed vector table, corner sequences, and random lines
// checked against a grammar-level line model.
module tb_serial_flash_cmd;

  localparam int unsigned TO = 40;  // MAIN_CLK/1000*TIMEOUT_MS with the overrides below

  logic        clk27 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_rx_char = 8'h00;
  logic        in_rx_valid = 1'b0;
  logic        in_cmd_ack = 1'b0;
  logic        out_cmd_valid, out_cmd_read, out_err, out_busy;
  logic [23:0] out_cmd_addr;
  logic [7:0]  out_cmd_data;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int req_seen = 0;
  int vcycles = 0;
  int unstable = 0;
  logic        prev_valid = 1'b0;
  logic        cap_read = 1'b0;
  logic [23:0] cap_addr = '0;
  logic [7:0]  cap_data = '0;

  serial_flash_cmd #(
    .WORD_BITS(8), .ADDRESS_WORDS(3), .MAIN_CLK(1000), .TIMEOUT_MS(TO)
  ) dut (
    .clk27(clk27), .rst(rst), .in_rx_char(in_rx_char), .in_rx_valid(in_rx_valid),
    .out_cmd_valid(out_cmd_valid), .in_cmd_ack(in_cmd_ack), .out_cmd_read(out_cmd_read),
    .out_cmd_addr(out_cmd_addr), .out_cmd_data(out_cmd_data), .out_err(out_err),
    .out_busy(out_busy)
  );

  always #5 clk27 = ~clk27;

  // Event monitor, sampled just after each rising edge.
  always begin
    @(posedge clk27);
    #1;
    if (out_err === 1'b1) err_seen++;
    if (out_cmd_valid === 1'b1) begin
      vcycles++;
      if (!prev_valid) begin
        req_seen++;
        cap_read = out_cmd_read;
        cap_addr = out_cmd_addr;
        cap_data = out_cmd_data;
      end else if (out_cmd_read !== cap_read || out_cmd_addr !== cap_addr ||
                   out_cmd_data !== cap_data) begin
        unstable++;
      end
    end
    prev_valid = (out_cmd_valid === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_char(input byte c, input int gap);
    in_rx_char  = c;
    in_rx_valid = 1'b1;
    @(negedge clk27);
    in_rx_valid = 1'b0;
    repeat (gap) @(negedge clk27);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 0);
  endtask

  function automatic int hexval(input byte c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  function automatic byte hexchar(input int v, input bit up);
    string digits;
    byte   c;
    digits = "0123456789abcdef";
    c = digits[v];
    if (up && c >= "a") c = c - 8'd32;
    return c;
  endfunction

  // Whole-line grammar model: leading spaces are skipped, the rest must match exactly.
  function automatic void model(input string line, output bit ok, output bit empty,
                                output bit rd, output logic [23:0] a, output logic [7:0] d);
    int    k;
    int    v;
    string s;
    k = 0;
    while (k < line.len() && line[k] == " ") k++;
    s = line.substr(k, line.len() - 1);
    empty = (s.len() == 0);
    ok = 1'b0; rd = 1'b0; a = '0; d = '0;
    if (s.len() == 8 && (s[0] == "R" || s[0] == "r")) begin ok = 1'b1; rd = 1'b1; end
    if (s.len() == 11 && (s[0] == "W" || s[0] == "w")) ok = 1'b1;
    if (ok && s[1] != " ") ok = 1'b0;
    for (int i = 2; i < 8; i++) begin
      if (ok) begin
        v = hexval(s[i]);
        if (v < 0) ok = 1'b0;
        else a = a * 16 + 24'(v);
      end
    end
    if (ok && !rd) begin
      if (s[8] != " ") ok = 1'b0;
      for (int i = 9; i < 11; i++) begin
        v = hexval(s[i]);
        if (v < 0) ok = 1'b0;
        else d = d * 16 + 8'(v);
      end
    end
    if (!ok) begin a = '0; d = '0; end
  endfunction

  task automatic run_line(input string name, input string body, input byte t1, input byte t2,
                          input int gap_max, input int ack_d, input bit exp_ok, input bit exp_rd,
                          input logic [23:0] exp_a, input logic [7:0] exp_d, input int exp_err);
    int e0, r0, v0;
    e0 = err_seen; r0 = req_seen; v0 = vcycles;
    for (int i = 0; i < body.len(); i++) send_char(body[i], $urandom_range(gap_max, 0));
    send_char(t1, 0);
    if (exp_ok) begin
      check({name, " valid"}, 32'(out_cmd_valid), 32'd1);
      repeat (ack_d) @(negedge clk27);
      in_cmd_ack = 1'b1;
      @(negedge clk27);
      in_cmd_ack = 1'b0;
    end
    repeat (2) @(negedge clk27);
    if (t2 != 8'h00) begin
      send_char(t2, 0);
      repeat (2) @(negedge clk27);
    end
    check({name, " reqs"}, 32'(req_seen - r0), exp_ok ? 32'd1 : 32'd0);
    check({name, " errs"}, 32'(err_seen - e0), 32'(exp_err));
    check({name, " busy"}, 32'(out_busy), 32'd0);
    if (exp_ok) begin
      check({name, " read"}, 32'(cap_read), 32'(exp_rd));
      check({name, " addr"}, 32'(cap_addr), 32'(exp_a));
      check({name, " data"}, 32'(cap_data), 32'(exp_d));
      check({name, " vcycles"}, 32'(vcycles - v0), 32'(ack_d + 1));
    end
  endtask

  typedef struct {
    string       body;
    byte         t1;
    byte         t2;
    int          ack_d;
    bit          ok;
    bit          rd;
    logic [23:0] a;
    logic [7:0]  d;
    int          err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int e0, r0;

    vecs[0] = '{body:"R 00012a",      t1:8'h0D, t2:8'h00, ack_d:0,  ok:1, rd:1, a:24'h00012A, d:8'h00, err:0};
    vecs[1] = '{body:"w ABCDEF 5f",   t1:8'h0A, t2:8'h00, ack_d:10, ok:1, rd:0, a:24'hABCDEF, d:8'h5F, err:0};
    vecs[2] = '{body:"R 0012g4",      t1:8'h0D, t2:8'h00, ack_d:0,  ok:0, rd:0, a:24'h0,      d:8'h00, err:1};
    vecs[3] = '{body:"R 000000",      t1:8'h0D, t2:8'h00, ack_d:0,  ok:1, rd:1, a:24'h000000, d:8'h00, err:0};
    vecs[4] = '{body:"",              t1:8'h0D, t2:8'h0A, ack_d:0,  ok:0, rd:0, a:24'h0,      d:8'h00, err:0};
    vecs[5] = '{body:"  W 123456 a0", t1:8'h0D, t2:8'h0A, ack_d:2,  ok:1, rd:0, a:24'h123456, d:8'hA0, err:0};
    vecs[6] = '{body:"X 000000",      t1:8'h0A, t2:8'h00, ack_d:0,  ok:0, rd:0, a:24'h0,      d:8'h00, err:1};
    vecs[7] = '{body:"W 000000",      t1:8'h0D, t2:8'h00, ack_d:0,  ok:0, rd:0, a:24'h0,      d:8'h00, err:1};
    vecs[8] = '{body:"r 000000 00",   t1:8'h0D, t2:8'h00, ack_d:0,  ok:0, rd:0, a:24'h0,      d:8'h00, err:1};
    vecs[9] = '{body:"R 00000",       t1:8'h0D, t2:8'h00, ack_d:0,  ok:0, rd:0, a:24'h0,      d:8'h00, err:1};

    // Reset state
    repeat (3) @(negedge clk27);
    check("rst valid", 32'(out_cmd_valid), 32'd0);
    check("rst read", 32'(out_cmd_read), 32'd1);
    check("rst addr", 32'(out_cmd_addr), 32'd0);
    check("rst data", 32'(out_cmd_data), 32'd0);
    check("rst err", 32'(out_err), 32'd0);
    check("rst busy", 32'(out_busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk27);

    for (int i = 0; i < 10; i++) begin
      run_line($sformatf("vec%0d", i), vecs[i].body, vecs[i].t1, vecs[i].t2, 1, vecs[i].ack_d,
               vecs[i].ok, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].err);
    end

    // Syntax error: pulse lands one cycle after the terminator, lasts one cycle.
    send_str("R 0012g4");
    check("syn err before cr", 32'(out_err), 32'd0);
    check("syn busy before cr", 32'(out_busy), 32'd1);
    send_char(8'h0D, 0);
    check("syn err pulse", 32'(out_err), 32'd1);
    check("syn busy after", 32'(out_busy), 32'd0);
    @(negedge clk27);
    check("syn err single", 32'(out_err), 32'd0);

    // Inter-character timeout boundary
    send_str("R 12");
    check("to busy mid", 32'(out_busy), 32'd1);
    repeat (TO - 1) @(negedge clk27);
    check("to err early", 32'(out_err), 32'd0);
    check("to busy early", 32'(out_busy), 32'd1);
    @(negedge clk27);
    check("to err", 32'(out_err), 32'd1);
    check("to busy", 32'(out_busy), 32'd0);
    @(negedge clk27);
    check("to err single", 32'(out_err), 32'd0);

    // Overrun during Issue
    send_str("W 0000AB 12");
    send_char(8'h0D, 2);
    send_char("x", 0);
    check("ovr err", 32'(out_err), 32'd1);
    check("ovr valid", 32'(out_cmd_valid), 32'd1);
    check("ovr addr", 32'(out_cmd_addr), 32'h0000AB);
    check("ovr data", 32'(out_cmd_data), 32'h12);
    check("ovr read", 32'(out_cmd_read), 32'd0);
    @(negedge clk27);
    check("ovr err single", 32'(out_err), 32'd0);
    repeat (3) @(negedge clk27);
    in_cmd_ack = 1'b1;
    @(negedge clk27);
    in_cmd_ack = 1'b0;
    check("ovr valid after ack", 32'(out_cmd_valid), 32'd0);
    check("ovr busy after ack", 32'(out_busy), 32'd0);

    // Ack and a character in the same cycle
    send_str("R 000001");
    send_char(8'h0D, 0);
    in_rx_char = "A"; in_rx_valid = 1'b1; in_cmd_ack = 1'b1;
    @(negedge clk27);
    in_rx_valid = 1'b0; in_cmd_ack = 1'b0;
    check("coin valid", 32'(out_cmd_valid), 32'd0);
    check("coin err", 32'(out_err), 32'd1);
    @(negedge clk27);
    check("coin busy", 32'(out_busy), 32'd0);

    // Reset mid-line
    e0 = err_seen; r0 = req_seen;
    send_str("W 000010 ");
    check("rml busy", 32'(out_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rml valid", 32'(out_cmd_valid), 32'd0);
    check("rml read", 32'(out_cmd_read), 32'd1);
    check("rml addr", 32'(out_cmd_addr), 32'd0);
    check("rml busy now", 32'(out_busy), 32'd0);
    @(negedge clk27);
    rst = 1'b0;
    in_cmd_ack = 1'b1;
    repeat (3) @(negedge clk27);
    in_cmd_ack = 1'b0;
    check("rml reqs", 32'(req_seen - r0), 32'd0);
    check("rml errs", 32'(err_seen - e0), 32'd0);

    // Reset during Issue
    send_str("R 000abc");
    send_char(8'h0D, 0);
    check("rsi valid before", 32'(out_cmd_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rsi valid", 32'(out_cmd_valid), 32'd0);
    check("rsi addr", 32'(out_cmd_addr), 32'd0);
    @(negedge clk27);
    rst = 1'b0;
    @(negedge clk27);

    // Random lines against the model
    for (int n = 0; n < 60; n++) begin
      string       s;
      bit          wr, ok, emp, rd;
      int          m;
      logic [23:0] a;
      logic [7:0]  d;
      byte         t1, t2;
      s  = "";
      wr = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) s = {s, " "};
      if (wr) s = {s, ($urandom_range(1, 0) != 0) ? "W " : "w "};
      else    s = {s, ($urandom_range(1, 0) != 0) ? "R " : "r "};
      for (int i = 0; i < 6; i++) begin
        s = $sformatf("%s%c", s, hexchar($urandom_range(15, 0), 1'($urandom_range(1, 0))));
      end
      if (wr) begin
        s = {s, " "};
        for (int i = 0; i < 2; i++) begin
          s = $sformatf("%s%c", s, hexchar($urandom_range(15, 0), 1'($urandom_range(1, 0))));
        end
      end
      m = $urandom_range(5, 0);
      if (m == 0) s[$urandom_range(s.len() - 1, 0)] = byte'($urandom_range(8'h7E, 8'h20));
      else if (m == 1) s = s.substr(0, s.len() - 2);
      else if (m == 2) s = $sformatf("%s%c", s, hexchar($urandom_range(15, 0), 1'b0));
      t1 = ($urandom_range(1, 0) != 0) ? 8'h0D : 8'h0A;
      t2 = ($urandom_range(3, 0) == 0) ? ((t1 == 8'h0D) ? 8'h0A : 8'h0D) : 8'h00;
      model(s, ok, emp, rd, a, d);
      run_line($sformatf("rnd%0d", n), s, t1, t2, 3, $urandom_range(5, 0), ok, rd, a, d,
               (!ok && !emp) ? 1 : 0);
    end

    check("outputs stable while valid", 32'(unstable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
